// File: rtl/phase_bank_ctrl.sv
// Double-buffered per-channel value store: host writes land in a shadow bank,
// which is copied to the active bank at a period boundary after a commit request.
module phase_bank_ctrl #(
   parameter int NUM_CH     = 64,
   parameter int WIDTH      = 11,
   parameter int WDOG_TICKS = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [5:0]              wr_addr,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic                    commit_req,
   input  logic                    period_tick,
   output logic [NUM_CH*WIDTH-1:0] active_flat,
   output logic                    commit_done,
   output logic                    armed,
   output logic                    err_addr,
   output logic                    wdog_trip,
   output logic [15:0]             frame_count
);

   localparam int CW = (WDOG_TICKS > 0) ? $clog2(WDOG_TICKS + 1) : 1;
   localparam logic [CW-1:0] WD_MAX = CW'(WDOG_TICKS);

   typedef enum logic {IDLE, ARMED} state_t;

   state_t                    state, state_nxt;
   logic [NUM_CH*WIDTH-1:0]   shadow_flat;
   logic [CW-1:0]             wd_cnt, wd_nxt;
   logic                      addr_ok, wr_en, commit, wd_tick, blank;

   assign addr_ok = ({1'b0, wr_addr} < 7'(NUM_CH));
   assign wr_en   = wr_valid & wr_ready & addr_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A tick in IDLE never commits, even alongside commit_req; it only feeds the watchdog.
   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      armed     = 1'b0;
      commit    = 1'b0;
      wd_tick   = 1'b0;
      case (state)
         IDLE: begin
            wr_ready = 1'b1;
            wd_tick  = period_tick;
            if (commit_req) state_nxt = ARMED;
         end
         ARMED: begin
            armed = 1'b1;
            if (period_tick) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wd_nxt = wd_cnt;
      blank  = 1'b0;
      if (WDOG_TICKS > 0 && wd_tick) begin
         if (wd_cnt != WD_MAX) wd_nxt = wd_cnt + CW'(1);
         blank = (wd_nxt == WD_MAX);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_done <= 1'b0;
         err_addr    <= 1'b0;
         wdog_trip   <= 1'b0;
         frame_count <= 16'd0;
         wd_cnt      <= '0;
      end else begin
         commit_done <= commit;
         if (wr_valid && wr_ready && !addr_ok) err_addr <= 1'b1;
         if (commit) begin
            frame_count <= frame_count + 16'd1;
            wd_cnt      <= '0;
            wdog_trip   <= 1'b0;
         end else begin
            wd_cnt <= wd_nxt;
            if (blank) wdog_trip <= 1'b1;
         end
      end
   end

   // Writes (IDLE) and commits (ARMED) are mutually exclusive, as are commit and blank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_flat <= '0;
         active_flat <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && wr_addr == 6'(i)) shadow_flat[i*WIDTH +: WIDTH] <= wr_data;
         end
         if (commit)     active_flat <= shadow_flat;
         else if (blank) active_flat <= '0;
      end
   end

endmodule

// File: tb/tb_phase_bank_ctrl.sv
// Bench for phase_bank_ctrl: two instances (64 ch / watchdog 4, 32 ch / watchdog off)
// share stimulus and are compared every cycle against an array-based reference model.
module tb_phase_bank_ctrl;

   logic        clk, rst, wr_valid, commit_req, period_tick;
   logic [5:0]  wr_addr;
   logic [10:0] wr_data;

   logic [703:0] a_flat;
   logic [351:0] b_flat;
   logic         a_ready, a_done, a_armed, a_err, a_trip;
   logic         b_ready, b_done, b_armed, b_err, b_trip;
   logic [15:0]  a_fc, b_fc;

   int n_cmp = 0;
   int n_err = 0;

   phase_bank_ctrl #(.NUM_CH(64), .WIDTH(11), .WDOG_TICKS(4)) u64 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(a_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .commit_req(commit_req), .period_tick(period_tick),
      .active_flat(a_flat), .commit_done(a_done), .armed(a_armed), .err_addr(a_err),
      .wdog_trip(a_trip), .frame_count(a_fc));

   phase_bank_ctrl #(.NUM_CH(32), .WIDTH(11), .WDOG_TICKS(0)) u32 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(b_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .commit_req(commit_req), .period_tick(period_tick),
      .active_flat(b_flat), .commit_done(b_done), .armed(b_armed), .err_addr(b_err),
      .wdog_trip(b_trip), .frame_count(b_fc));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model state, index 0 = 64-channel instance, 1 = 32-channel instance
   int          nch[2] = '{64, 32};
   int          wdt[2] = '{4, 0};
   logic [10:0] m_sh[2][64];
   logic [10:0] m_act[2][64];
   bit          m_armed[2], m_err[2], m_trip[2], m_done[2];
   int          m_fc[2], m_wd[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 64; c++) begin
            m_sh[k][c]  = '0;
            m_act[k][c] = '0;
         end
         m_armed[k] = 0; m_err[k] = 0; m_trip[k] = 0; m_done[k] = 0;
         m_fc[k] = 0; m_wd[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit d = 0;
         if (!m_armed[k]) begin
            if (wr_valid) begin
               if (int'(wr_addr) < nch[k]) m_sh[k][wr_addr] = wr_data;
               else m_err[k] = 1;
            end
            if (period_tick && wdt[k] > 0) begin
               if (m_wd[k] < wdt[k]) m_wd[k]++;
               if (m_wd[k] == wdt[k]) begin
                  for (int c = 0; c < 64; c++) m_act[k][c] = '0;
                  m_trip[k] = 1;
               end
            end
            if (commit_req) m_armed[k] = 1;
         end else if (period_tick) begin
            for (int c = 0; c < 64; c++) m_act[k][c] = m_sh[k][c];
            m_fc[k]    = (m_fc[k] + 1) % 65536;
            m_wd[k]    = 0;
            m_trip[k]  = 0;
            m_armed[k] = 0;
            d = 1;
         end
         m_done[k] = d;
      end
   endtask

   function automatic logic [703:0] mflat(int k);
      logic [703:0] r = '0;
      for (int c = 0; c < nch[k]; c++) r[c*11 +: 11] = m_act[k][c];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [703:0] obs, input logic [703:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a_active", a_flat, mflat(0));
      chk("a_ready", 704'(a_ready), 704'(!m_armed[0]));
      chk("a_armed", 704'(a_armed), 704'(m_armed[0]));
      chk("a_done", 704'(a_done), 704'(m_done[0]));
      chk("a_err", 704'(a_err), 704'(m_err[0]));
      chk("a_trip", 704'(a_trip), 704'(m_trip[0]));
      chk("a_fc", 704'(a_fc), 704'(m_fc[0]));
      chk("b_active", 704'(b_flat), mflat(1));
      chk("b_ready", 704'(b_ready), 704'(!m_armed[1]));
      chk("b_armed", 704'(b_armed), 704'(m_armed[1]));
      chk("b_done", 704'(b_done), 704'(m_done[1]));
      chk("b_err", 704'(b_err), 704'(m_err[1]));
      chk("b_trip", 704'(b_trip), 704'(m_trip[1]));
      chk("b_fc", 704'(b_fc), 704'(m_fc[1]));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic wr(input logic [5:0] a, input logic [10:0] d);
      wr_addr = a; wr_data = d; wr_valid = 1'b1;
      cyc();
      wr_valid = 1'b0;
   endtask

   task automatic tick();
      period_tick = 1'b1;
      cyc();
      period_tick = 1'b0;
   endtask

   task automatic commit_tick();
      commit_req = 1'b1;
      cyc();
      commit_req = 1'b0;
      tick();
      cyc();
   endtask

   initial begin
      rst = 1'b0; wr_valid = 1'b0; commit_req = 1'b0; period_tick = 1'b0;
      wr_addr = '0; wr_data = '0;
      #1 rst = 1'b1;
      #2;
      model_reset();
      check_all();
      chk("rst_a_fc", 704'(a_fc), 704'(0));
      #9 rst = 1'b0;

      // basic commit; ch63 is out of range for the 32-channel instance
      wr(6'd5, 11'h2A5);
      wr(6'd63, 11'h7FF);
      repeat (3) tick();
      chk("nocommit_active", a_flat, 704'(0));
      commit_req = 1'b1; cyc(); commit_req = 1'b0;
      tick();
      chk("ch5", 704'(a_flat[5*11 +: 11]), 704'(11'h2A5));
      chk("ch63", 704'(a_flat[63*11 +: 11]), 704'(11'h7FF));
      chk("done_pulse", 704'(a_done), 704'(1));
      chk("fc1", 704'(a_fc), 704'(1));
      chk("b_err_set", 704'(b_err), 704'(1));
      cyc();
      chk("done_one_cycle", 704'(a_done), 704'(0));

      // armed stall: write held while armed is deferred past the commit
      commit_req = 1'b1; cyc(); commit_req = 1'b0;
      wr_addr = 6'd0; wr_data = 11'h100; wr_valid = 1'b1;
      cyc();
      chk("stall_ready", 704'(a_ready), 704'(0));
      cyc();
      tick();
      chk("stall_old_ch0", 704'(a_flat[10:0]), 704'(0));
      cyc();
      wr_valid = 1'b0;
      commit_tick();
      chk("stall_new_ch0", 704'(a_flat[10:0]), 704'(11'h100));

      // commit_req together with tick in IDLE does not commit
      commit_req = 1'b1; period_tick = 1'b1; cyc();
      commit_req = 1'b0; period_tick = 1'b0;
      chk("same_cycle_armed", 704'(a_armed), 704'(1));
      chk("same_cycle_fc", 704'(a_fc), 704'(3));
      tick();
      chk("next_tick_fc", 704'(a_fc), 704'(4));

      // write and commit_req in the same cycle: write is included
      wr_addr = 6'd7; wr_data = 11'h3C3; wr_valid = 1'b1; commit_req = 1'b1;
      cyc();
      wr_valid = 1'b0; commit_req = 1'b0;
      tick();
      chk("wr_commit_ch7", 704'(a_flat[7*11 +: 11]), 704'(11'h3C3));

      // watchdog
      wr(6'd1, 11'h055);
      commit_tick();
      repeat (3) tick();
      chk("wd_pre_trip", 704'(a_trip), 704'(0));
      tick();
      chk("wd_trip", 704'(a_trip), 704'(1));
      chk("wd_blank", a_flat, 704'(0));
      chk("wd_off_b", 704'(b_trip), 704'(0));
      tick();
      chk("wd_hold_blank", a_flat, 704'(0));
      commit_tick();
      chk("wd_restore_ch1", 704'(a_flat[1*11 +: 11]), 704'(11'h055));
      chk("wd_cleared", 704'(a_trip), 704'(0));
      chk("b_err_sticky", 704'(b_err), 704'(1));

      // reset while armed
      commit_req = 1'b1; cyc(); commit_req = 1'b0;
      #3 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_armed", 704'(a_armed), 704'(0));
      chk("rst_active", a_flat, 704'(0));
      check_all();
      #2 rst = 1'b0;

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         wr_valid    = 1'($urandom_range(0, 1));
         wr_addr     = 6'($urandom_range(0, 63));
         wr_data     = 11'($urandom);
         commit_req  = ($urandom_range(0, 7) == 0);
         period_tick = ($urandom_range(0, 4) == 0);
         cyc();
      end
      wr_valid = 1'b0; commit_req = 1'b0; period_tick = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/phase_bank_ctrl.md
Name: phase_bank_ctrl

Overview:
- Double-buffered value store sitting between the SPI receive path (11-bit value plus 6-bit channel index) and the 64 per-channel signal_shift generators.
- Host writes go to a shadow bank.
- On a commit request, the whole shadow bank is copied atomically into the active bank at the next output-period boundary, so all channels change phase/duty in the same period.
- A period watchdog blanks every channel if the host stops committing.

Parameters:
NUM_CH, 64, number of channels (max 64, index width 6)
WIDTH, 11, bits per channel value
WDOG_TICKS, 1000, period_ticks without a commit before blanking; 0 disables the watchdog

Ports:
clk  input  1  system clock; one clock domain, all inputs synchronous to it
rst  input  1  asynchronous, active-high reset
wr_valid  input  1  channel write request (already synchronised to clk)
wr_ready  output  1  write accepted when wr_valid & wr_ready
wr_addr  input  6  channel index
wr_data  input  WIDTH  channel value
commit_req  input  1  single-cycle pulse: arm a shadow-to-active copy
period_tick  input  1  single-cycle pulse at the start of each output period
active_flat  output  NUM_CH*WIDTH  active bank; channel i is at bits [i*WIDTH +: WIDTH]
commit_done  output  1  one-cycle pulse, the cycle after the copy
armed  output  1  high while a commit is pending
err_addr  output  1  sticky: a write with wr_addr >= NUM_CH was dropped
wdog_trip  output  1  sticky: watchdog blanked the active bank
frame_count  output  16  number of completed commits, wraps at 65535 -> 0

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - shadow and active banks all 0; state IDLE.
  - wr_ready=1; armed, commit_done, err_addr, wdog_trip = 0.
  - frame_count=0; watchdog counter=0.
- States:
  - IDLE: wr_ready=1, armed=0.
  - ARMED: wr_ready=0, armed=1; the shadow bank is frozen.
- Writes:
  - In IDLE, wr_valid=1 with wr_addr < NUM_CH writes shadow[wr_addr] at that edge. active_flat is unaffected.
  - A write with wr_addr >= NUM_CH is dropped and sets err_addr. err_addr clears only on rst.
  - In ARMED, wr_ready=0 and wr_valid is ignored. The source must hold its request.
- IDLE -> ARMED:
  - On commit_req=1.
  - If wr_valid and commit_req are high in the same IDLE cycle, the write is accepted first, then the state becomes ARMED.
  - commit_req while already ARMED is ignored.
- ARMED -> IDLE:
  - On period_tick=1: active <= shadow for all channels in one edge.
  - frame_count increments, the watchdog counter clears, wdog_trip clears.
  - commit_done=1 on the next cycle only.
- Latency and same-cycle cases:
  - A period_tick in the same cycle as commit_req, while in IDLE, does NOT commit; the earliest commit is the next tick.
  - Minimum latency from commit_req to active change is 1 edge after the following tick.
  - A period_tick in IDLE only affects the watchdog.
- Watchdog (WDOG_TICKS > 0):
  - The counter increments on each period_tick that does not commit, saturating at WDOG_TICKS.
  - On the tick where it reaches WDOG_TICKS: all active values are forced to 0 and wdog_trip=1. The shadow bank is retained.
  - Further ticks keep active at 0 until the next commit.
  - If a commit and the threshold coincide on the same tick, the commit wins: active=shadow, wdog_trip stays 0.
- WDOG_TICKS=0: the counter never advances and wdog_trip stays 0.
- rst asserted while ARMED abandons the pending commit. The active bank goes to 0, not to the shadow contents.
- active_flat is driven directly from registers (no output logic), so each generator sees a glitch-free value.

Test Plan:
- Post-reset check: rst pulse -> active_flat=0, wr_ready=1, armed=0, frame_count=0.
- Basic commit: write ch5=0x2A5, ch63=0x7FF, no commit, 3 ticks -> active_flat unchanged (all 0). Then commit_req, tick -> ch5=0x2A5, ch63=0x7FF; commit_done for exactly 1 cycle; frame_count=1.
- Armed stall: commit_req, then hold wr_valid with ch0=0x100 -> wr_ready=0 and shadow unchanged. After tick: active ch0 = old value, write accepted the next cycle; a second commit+tick gives ch0=0x100.
- Same-cycle edges:
  - commit_req and tick in the same IDLE cycle -> no commit; the next tick commits.
  - wr_valid and commit_req together -> that write is included in the commit.
- Bad address: wr_addr=63 with NUM_CH=32 -> write dropped, err_addr=1 and still set after a later commit.
- Watchdog: WDOG_TICKS=4, commit ch1=0x055, then 4 ticks without commit -> active all 0 and wdog_trip=1 on the 4th tick. commit_req+tick -> ch1=0x055, wdog_trip=0. Also assert rst mid-ARMED -> active 0, armed 0 immediately.
